// File: rtl/single_cycle_top.sv
// single_cycle_top - single-cycle RV32I-subset core (fetch, decode, execute,
// memory and writeback all complete within one clock).
// Optional feature macro: SC_ECALL_HALT_EN -- when defined, ECALL/EBREAK set a
// sticky halt flag that freezes the core until reset; when undefined they are NOPs.

module sc_imem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [31:0] addr,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] memory [0:DEPTH-1];

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) % 32'(DEPTH);
    return w[AW-1:0];
  endfunction

  assign rdata = memory[word_idx(addr)];

  // Load port for in-system programming; the core itself never writes code
  always_ff @(posedge clk) if (we) memory[word_idx(waddr)] <= wdata;
endmodule

module sc_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];

  // Single write port; x0 is hardwired so its writes are discarded
  always_ff @(posedge clk) if (we && (wa != 5'd0)) registers[wa] <= wd;
endmodule

module sc_dmem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] memory [0:DEPTH-1];

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) % 32'(DEPTH);
    return w[AW-1:0];
  endfunction

  assign rdata = memory[word_idx(addr)];

  // Word store; low address bits are ignored and the index wraps
  always_ff @(posedge clk) if (we) memory[word_idx(addr)] <= wdata;
endmodule

module single_cycle_top #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input logic clk,
  input logic rst_n  // active-high despite the name
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [31:0] pc, inst, alu_result, next_pc;
  logic [31:0] rs1_data, rs2_data, wb_data, dmem_rdata;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        rd_we, dmem_we, is_load, is_link, freeze;
  logic        rf_we_g, dmem_we_g;
`ifdef SC_ECALL_HALT_EN
  logic        halt_req, halted;
`endif

  sc_imem #(.DEPTH(IMEM_DEPTH)) imem (
    .clk(clk), .we(1'b0), .waddr(32'd0), .wdata(32'd0), .addr(pc), .rdata(inst)
  );

  sc_regfile reg_file (
    .clk(clk), .we(rf_we_g), .ra1(rs1), .ra2(rs2), .wa(rd), .wd(wb_data),
    .rd1(rs1_data), .rd2(rs2_data)
  );

  sc_dmem #(.DEPTH(DMEM_DEPTH)) dmem (
    .clk(clk), .we(dmem_we_g), .addr(alu_result), .wdata(rs2_data), .rdata(dmem_rdata)
  );

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  alu_op = alt ? (a - b) : (a + b);
      3'b001:  alu_op = a << b[4:0];
      3'b010:  alu_op = {31'd0, sa < sb};
      3'b011:  alu_op = {31'd0, a < b};
      3'b100:  alu_op = a ^ b;
      3'b101:  if (alt) alu_op = sa >>> b[4:0];
               else     alu_op = a >> b[4:0];
      3'b110:  alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  function automatic logic r_valid(input logic [6:0] f7, input logic [2:0] f3);
    return (f7 == 7'b0000000) ||
           ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
  endfunction

  function automatic logic i_valid(input logic [6:0] f7, input logic [2:0] f3);
    case (f3)
      3'b001:  return f7 == 7'b0000000;
      3'b101:  return (f7 == 7'b0000000) || (f7 == 7'b0100000);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      default: return a >= b;
    endcase
  endfunction

  // Decode and execute: ALU/address result, next PC and write intents
  always_comb begin
    alu_result = 32'd0;
    next_pc    = pc + 32'd4;
    rd_we      = 1'b0;
    dmem_we    = 1'b0;
    is_load    = 1'b0;
    is_link    = 1'b0;
`ifdef SC_ECALL_HALT_EN
    halt_req   = 1'b0;
`endif
    case (opcode)
      OP_R: if (r_valid(funct7, funct3)) begin
        alu_result = alu_op(funct3, funct7[5], rs1_data, rs2_data);
        rd_we      = 1'b1;
      end
      OP_I: if (i_valid(funct7, funct3)) begin
        alu_result = alu_op(funct3, (funct3 == 3'b101) && funct7[5], rs1_data, imm_i);
        rd_we      = 1'b1;
      end
      OP_LOAD: if (funct3 == 3'b010) begin
        alu_result = rs1_data + imm_i;
        rd_we      = 1'b1;
        is_load    = 1'b1;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        alu_result = rs1_data + imm_s;
        dmem_we    = 1'b1;
      end
      OP_BRANCH: if ((funct3 != 3'b010) && (funct3 != 3'b011)) begin
        alu_result = rs1_data - rs2_data;
        if (branch_taken(funct3, rs1_data, rs2_data)) next_pc = pc + imm_b;
      end
      OP_JAL: begin
        alu_result = pc + imm_j;
        next_pc    = alu_result;
        rd_we      = 1'b1;
        is_link    = 1'b1;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        alu_result = (rs1_data + imm_i) & ~32'd1;
        next_pc    = alu_result;
        rd_we      = 1'b1;
        is_link    = 1'b1;
      end
      OP_LUI: begin
        alu_result = imm_u;
        rd_we      = 1'b1;
      end
      OP_AUIPC: begin
        alu_result = pc + imm_u;
        rd_we      = 1'b1;
      end
`ifdef SC_ECALL_HALT_EN
      7'b1110011: halt_req = (inst == 32'h0000_0073) || (inst == 32'h0010_0073);
`endif
      default: ;
    endcase
  end

  assign wb_data = is_load ? dmem_rdata : (is_link ? (pc + 32'd4) : alu_result);

`ifdef SC_ECALL_HALT_EN
  // Sticky halt flag: set by ECALL/EBREAK, cleared only by reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)         halted <= 1'b0;
    else if (halt_req) halted <= 1'b1;
  end
  assign freeze = halted | halt_req;
`else
  assign freeze = 1'b0;
`endif

  // Reset held at an edge abandons the instruction's architectural writes
  assign rf_we_g   = rd_we   & ~rst_n & ~freeze;
  assign dmem_we_g = dmem_we & ~rst_n & ~freeze;

  // Program counter: async reset, retires one instruction per edge unless frozen
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)        pc <= RESET_PC;
    else if (!freeze) pc <= next_pc;
  end
endmodule

// File: tb/tb_single_cycle_top.sv
// tb_single_cycle_top - directed and randomized checks of single_cycle_top
// against an instruction-level reference model.
module tb_single_cycle_top;
  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  single_cycle_top #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .RESET_PC(32'd0))
    dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [31:0] m_imem [IMEM_DEPTH];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [DMEM_DEPTH];
  logic [31:0] m_pc;
  bit          m_halt;

  // Expected effects of the instruction currently at m_pc
  logic [31:0] e_alu, e_npc, e_rval, e_sval;
  logic [4:0]  e_rd;
  bit          e_alu_def, e_wr, e_st, e_hlt;
  int unsigned e_sidx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put_inst(input int idx, input logic [31:0] w);
    dut.imem.memory[idx] = w;
    m_imem[idx] = w;
  endtask

  task automatic put_reg(input int r, input logic [31:0] v);
    dut.reg_file.registers[r] = v;
    m_regs[r] = v;
  endtask

  task automatic put_dmem(input int idx, input logic [31:0] v);
    dut.dmem.memory[idx] = v;
    m_dmem[idx] = v;
  endtask

  // Instruction encoders
  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_ins(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_ins(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] j_ins(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] rreg(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : m_regs[r];
  endfunction

  // Interpret the instruction at m_pc according to the ISA rules
  task automatic model_decode();
    logic [31:0] in, a, b, r, t, pc4;
    logic signed [31:0] sr;
    int si, ss, sb, sj;
    int unsigned wi;
    bit ok, tk;
    wi = (m_pc >> 2) % 32'(IMEM_DEPTH);
    in = m_imem[wi];
    a  = rreg(in[19:15]);
    b  = rreg(in[24:20]);
    si = int'($signed(in[31:20]));
    ss = int'($signed({in[31:25], in[11:7]}));
    sb = int'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
    sj = int'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
    pc4 = m_pc + 32'd4;
    e_alu_def = 0; e_alu = 32'd0; e_npc = pc4; e_wr = 0; e_rd = in[11:7];
    e_rval = 32'd0; e_st = 0; e_sidx = 0; e_sval = 32'd0; e_hlt = 0;
    r = 32'd0; ok = 1; tk = 0;
    if (m_halt) begin
      e_npc = m_pc;
      return;
    end
    case (in[6:0])
      7'h33: begin
        case ({in[31:25], in[14:12]})
          10'h000: r = a + b;
          10'h100: r = a - b;
          10'h001: r = a << b[4:0];
          10'h002: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          10'h003: r = (a < b) ? 32'd1 : 32'd0;
          10'h004: r = a ^ b;
          10'h005: r = a >> b[4:0];
          10'h105: begin sr = $signed(a); sr = sr >>> b[4:0]; r = sr; end
          10'h006: r = a | b;
          10'h007: r = a & b;
          default: ok = 0;
        endcase
        if (ok) begin e_alu_def = 1; e_alu = r; e_wr = 1; e_rval = r; end
      end
      7'h13: begin
        case (in[14:12])
          3'd0: r = a + 32'(si);
          3'd2: r = ($signed(a) < si) ? 32'd1 : 32'd0;
          3'd3: r = (a < 32'(si)) ? 32'd1 : 32'd0;
          3'd4: r = a ^ 32'(si);
          3'd6: r = a | 32'(si);
          3'd7: r = a & 32'(si);
          3'd1: if (in[31:25] == 7'h00) r = a << in[24:20]; else ok = 0;
          default: begin
            if (in[31:25] == 7'h00) r = a >> in[24:20];
            else if (in[31:25] == 7'h20) begin sr = $signed(a); sr = sr >>> in[24:20]; r = sr; end
            else ok = 0;
          end
        endcase
        if (ok) begin e_alu_def = 1; e_alu = r; e_wr = 1; e_rval = r; end
      end
      7'h03: if (in[14:12] == 3'd2) begin
        t = a + 32'(si);
        e_alu_def = 1; e_alu = t; e_wr = 1;
        e_rval = m_dmem[(t >> 2) % 32'(DMEM_DEPTH)];
      end
      7'h23: if (in[14:12] == 3'd2) begin
        t = a + 32'(ss);
        e_alu_def = 1; e_alu = t; e_st = 1;
        e_sidx = (t >> 2) % 32'(DMEM_DEPTH); e_sval = b;
      end
      7'h63: begin
        case (in[14:12])
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: ok = 0;
        endcase
        if (ok) begin
          e_alu_def = 1; e_alu = a - b;
          if (tk) e_npc = m_pc + 32'(sb);
        end
      end
      7'h6f: begin
        t = m_pc + 32'(sj);
        e_alu_def = 1; e_alu = t; e_npc = t; e_wr = 1; e_rval = pc4;
      end
      7'h67: if (in[14:12] == 3'd0) begin
        t = (a + 32'(si)) & ~32'd1;
        e_alu_def = 1; e_alu = t; e_npc = t; e_wr = 1; e_rval = pc4;
      end
      7'h37: begin e_alu_def = 1; e_alu = in & 32'hFFFF_F000; e_wr = 1; e_rval = e_alu; end
      7'h17: begin e_alu_def = 1; e_alu = m_pc + (in & 32'hFFFF_F000); e_wr = 1; e_rval = e_alu; end
`ifdef SC_ECALL_HALT_EN
      7'h73: if (in == 32'h0000_0073 || in == 32'h0010_0073) begin e_hlt = 1; e_npc = m_pc; end
`endif
      default: ;
    endcase
  endtask

  // One clock: check the in-cycle view, retire in the model, check results
  task automatic step(input string tag);
    model_decode();
    check({tag, ".pc"}, dut.pc, m_pc);
    if (e_alu_def) check({tag, ".alu"}, dut.alu_result, e_alu);
    @(posedge clk);
    #1;
    if (e_wr && e_rd != 5'd0) m_regs[e_rd] = e_rval;
    if (e_st) m_dmem[e_sidx] = e_sval;
    m_pc = e_npc;
    if (e_hlt) m_halt = 1;
    if (e_wr) check({tag, ".rd"}, dut.reg_file.registers[e_rd], m_regs[e_rd]);
    if (e_st) check({tag, ".st"}, dut.dmem.memory[e_sidx], m_dmem[e_sidx]);
    @(negedge clk);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 32'd0;
    m_halt = 0;
    #1;
    check("rst.pc", dut.pc, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] imm;
    int t;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3 = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    t = int'($urandom_range(0, 16));
    case ($urandom_range(0, 10))
      0, 1: begin
        if ($urandom_range(0, 9) == 0) f7 = 7'($urandom);
        else f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return r_ins(f7, rs2, rs1, f3, rd, 7'h33);
      end
      2, 3: begin
        if (f3 == 3'd1) imm[11:5] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return i_ins(imm, rs1, f3, rd, 7'h13);
      end
      4: return i_ins(imm, rs1, ($urandom_range(0, 7) == 0) ? f3 : 3'd2, rd, 7'h03);
      5: return s_ins(imm, rs2, rs1, ($urandom_range(0, 7) == 0) ? f3 : 3'd2);
      6, 7: return b_ins(13'((t - 8) * 4), rs2, rs1, f3);
      8: return ($urandom_range(0, 1) == 1) ? j_ins(21'((t - 8) * 4), rd)
                                            : i_ins(imm, rs1, ($urandom_range(0, 5) == 0) ? f3 : 3'd0, rd, 7'h67);
      9: return {20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
      default: return {25'($urandom), 7'h0b};
    endcase
  endfunction

  initial begin
    #1 rst_n = 1'b1;
    for (int i = 0; i < IMEM_DEPTH; i++) put_inst(i, NOP);
    for (int i = 0; i < 32; i++) put_reg(i, 32'd0);
    for (int i = 0; i < DMEM_DEPTH; i++) put_dmem(i, 32'd0);
    put_reg(2, 32'd10); put_reg(3, 32'd20); put_reg(5, 32'd50); put_reg(6, 32'd15);

    // Program A: ALU, x0, store/load, branches, then reset during a JAL
    put_inst(0, r_ins(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33));  // ADD x1,x2,x3
    put_inst(1, r_ins(7'h20, 5'd6, 5'd5, 3'd0, 5'd4, 7'h33));  // SUB x4,x5,x6
    put_inst(2, i_ins(12'd5, 5'd0, 3'd0, 5'd0, 7'h13));        // ADDI x0,x0,5
    put_inst(3, s_ins(12'd8, 5'd3, 5'd0, 3'd2));               // SW x3,8(x0)
    put_inst(4, i_ins(12'd8, 5'd0, 3'd2, 5'd7, 7'h03));        // LW x7,8(x0)
    put_inst(5, b_ins(13'd12, 5'd2, 5'd2, 3'd1));              // BNE x2,x2,+12
    put_inst(6, b_ins(13'd12, 5'd2, 5'd2, 3'd0));              // BEQ x2,x2,+12
    put_inst(9, j_ins(21'h1FFFF0, 5'd1));                      // JAL x1,-16
    hold_reset();
    release_reset();
    check("add.alu", dut.alu_result, 32'd30);
    step("add");
    check("add.x1", dut.reg_file.registers[1], 32'd30);
    check("add.pcn", dut.pc, 32'd4);
    check("sub.alu", dut.alu_result, 32'd35);
    step("sub");
    check("sub.x4", dut.reg_file.registers[4], 32'd35);
    step("addi_x0");
    check("x0.zero", dut.reg_file.registers[0], 32'd0);
    step("sw");
    check("sw.mem2", dut.dmem.memory[2], 32'd20);
    step("lw");
    check("lw.x7", dut.reg_file.registers[7], 32'd20);
    step("bne");
    check("bne.pc", dut.pc, 32'd24);
    step("beq");
    check("beq.pc", dut.pc, 32'd36);
    #2 rst_n = 1'b1;
    m_pc = 32'd0;
    #1 check("arst.pc", dut.pc, 32'd0);
    @(posedge clk);
    #1;
    check("arst.x1", dut.reg_file.registers[1], 32'd30);
    check("arst.x4", dut.reg_file.registers[4], 32'd35);
    check("arst.pch", dut.pc, 32'd0);

    // Program B: taken/untaken branches and a backward JAL with link
    for (int i = 0; i < 10; i++) put_inst(i, NOP);
    put_inst(3, b_ins(13'd12, 5'd2, 5'd2, 3'd1));   // BNE at 12
    put_inst(4, b_ins(13'd12, 5'd2, 5'd2, 3'd0));   // BEQ at 16
    put_inst(7, j_ins(21'h1FFFF0, 5'd1));           // JAL at 28
    release_reset();
    for (int i = 0; i < 4; i++) step("progb");
    check("b.bne.pc", dut.pc, 32'd16);
    step("b.beq");
    check("b.beq.pc", dut.pc, 32'd28);
    step("b.jal");
    check("b.jal.x1", dut.reg_file.registers[1], 32'd32);
    check("b.jal.pc", dut.pc, 32'd12);

    // Program C: ECALL at pc=8
    hold_reset();
    for (int i = 0; i < 10; i++) put_inst(i, NOP);
    put_inst(2, 32'h0000_0073);
    release_reset();
    step("c0");
    step("c1");
    step("ecall");
`ifdef SC_ECALL_HALT_EN
    check("ecall.pc", dut.pc, 32'd8);
    for (int i = 0; i < 4; i++) begin
      step("halted");
      check("halt.pc", dut.pc, 32'd8);
    end
`else
    check("ecall.pc", dut.pc, 32'd12);
`endif
    hold_reset();
    release_reset();
    step("unhalt");
    check("unhalt.pc", dut.pc, 32'd4);

    // Randomized programs over the whole instruction/data space
    for (int round = 0; round < 3; round++) begin
      hold_reset();
      for (int i = 0; i < IMEM_DEPTH; i++) put_inst(i, rand_inst());
      for (int i = 0; i < 32; i++) put_reg(i, $urandom);
      for (int i = 0; i < DMEM_DEPTH; i++) put_dmem(i, $urandom);
      release_reset();
      for (int s = 0; s < 300; s++) step("rnd");
      for (int r = 0; r < 32; r++) check("rnd.reg", dut.reg_file.registers[r], m_regs[r]);
      for (int d = 0; d < DMEM_DEPTH; d++) check("rnd.dmem", dut.dmem.memory[d], m_dmem[d]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
